// File: rtl/usb_rx_phy_if.sv
// Pad-side and SIE-side signals of the USB receive front-end.
// The master side drives the pads and rx_en; the slave side is the receiver.
interface usb_rx_phy_if;
  logic [1:0] d_i;
  logic       rx_en;
  logic [1:0] line_state;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic       bus_reset;

  modport master (
    output d_i, rx_en,
    input  line_state, rx_data, rx_valid, rx_active, rx_error, bus_reset
  );

  modport slave (
    input  d_i, rx_en,
    output line_state, rx_data, rx_valid, rx_active, rx_error, bus_reset
  );
endinterface

// File: rtl/usb_rx_phy.sv
// USB receive front-end: synchroniser, edge-locked bit recovery, NRZI decode,
// bit unstuffing, SYNC/EOP framing and bus-reset detection.
module usb_rx_phy #(
  parameter int unsigned CLK_PER_BIT  = 16,
  parameter bit          LOW_SPEED    = 1'b1,
  parameter int unsigned RESET_CYCLES = 60
) (
  input  logic         clk,
  input  logic         reset_n,
  usb_rx_phy_if.slave  bus
);

  localparam int unsigned PW = $clog2(CLK_PER_BIT);
  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CLK_PER_BIT / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_BIT - 1);
  localparam logic [RW-1:0] SE0_MAX = RW'(RESET_CYCLES);
  localparam logic [1:0] SYM_J   = LOW_SPEED ? 2'b01 : 2'b10;
  localparam logic [1:0] SYM_K   = LOW_SPEED ? 2'b10 : 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERROR
  } state_e;

  logic [1:0]    meta_q, line_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [RW-1:0] se0_cnt_q;
  logic          bus_reset_q;
  state_e        state_q;
  logic [1:0]    prev_q;
  logic [2:0]    cnt_q;
  logic [2:0]    ones_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, rx_active_q, rx_error_q;
  logic          strobe_c;
  logic          bit_c;
  logic [1:0]    sync_exp_c;

  // Two-flop synchroniser for the asynchronous pad pair
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 2'b00;
      line_q <= 2'b00;
    end else begin
      meta_q <= bus.d_i;
      line_q <= meta_q;
    end
  end

  // Phase counter realigns on every line transition so the strobe lands mid-bit
  always_comb begin
    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    if (meta_q != line_q) phase_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) phase_q <= '0;
    else          phase_q <= phase_d;
  end

  assign strobe_c   = (phase_q == PH_HALF);
  assign bit_c      = (line_q == prev_q);
  assign sync_exp_c = ((cnt_q == 3'd7) || !cnt_q[0]) ? SYM_K : SYM_J;

  // SE0 duration counter, independent of the framing state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      se0_cnt_q   <= '0;
      bus_reset_q <= 1'b0;
    end else if (line_q == SYM_SE0) begin
      if (se0_cnt_q != SE0_MAX) se0_cnt_q <= se0_cnt_q + RW'(1);
      bus_reset_q <= (se0_cnt_q >= SE0_MAX - RW'(1));
    end else begin
      se0_cnt_q   <= '0;
      bus_reset_q <= 1'b0;
    end
  end

  // Framing FSM; cnt_q is the SYNC index, data bit count, EOP SE0 count or J run
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      prev_q      <= SYM_J;
      cnt_q       <= 3'd0;
      ones_q      <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      if (!bus.rx_en) begin
        state_q     <= ST_IDLE;
        prev_q      <= SYM_J;
        rx_active_q <= 1'b0;
      end else if (strobe_c) begin
        unique case (state_q)
          ST_IDLE: begin
            if (line_q == SYM_K) begin
              state_q <= ST_SYNC;
              prev_q  <= SYM_K;
              cnt_q   <= 3'd1;
            end
          end
          ST_SYNC: begin
            if (line_q == sync_exp_c) begin
              prev_q <= line_q;
              cnt_q  <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                state_q     <= ST_DATA;
                rx_active_q <= 1'b1;
                ones_q      <= 3'd0;
              end
            end else begin
              state_q <= ST_IDLE;
              prev_q  <= SYM_J;
            end
          end
          ST_DATA: begin
            if (line_q == SYM_SE0) begin
              rx_active_q <= (cnt_q == 3'd0);
              rx_error_q  <= (cnt_q != 3'd0);
              state_q     <= (cnt_q == 3'd0) ? ST_EOP : ST_ERROR;
              cnt_q       <= (cnt_q == 3'd0) ? 3'd1 : 3'd0;
            end else begin
              prev_q <= line_q;
              if (ones_q == 3'd6) begin
                // Stuff bit slot: a 0 is discarded, a 1 is a stuffing violation
                ones_q <= 3'd0;
                if (bit_c) begin
                  state_q     <= ST_ERROR;
                  rx_active_q <= 1'b0;
                  rx_error_q  <= 1'b1;
                  cnt_q       <= 3'd0;
                end
              end else begin
                ones_q  <= bit_c ? ones_q + 3'd1 : 3'd0;
                shift_q <= {bit_c, shift_q[7:1]};
                cnt_q   <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                  rx_data_q  <= {bit_c, shift_q[7:1]};
                  rx_valid_q <= 1'b1;
                end
              end
            end
          end
          ST_EOP: begin
            if (line_q == SYM_J) begin
              state_q     <= ST_IDLE;
              prev_q      <= SYM_J;
              rx_active_q <= 1'b0;
            end else if (line_q == SYM_SE0 && cnt_q != 3'd2) begin
              cnt_q <= cnt_q + 3'd1;
            end else begin
              state_q     <= ST_ERROR;
              rx_active_q <= 1'b0;
              rx_error_q  <= 1'b1;
              cnt_q       <= 3'd0;
            end
          end
          ST_ERROR: begin
            if (line_q == SYM_J) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd6) begin
                state_q <= ST_IDLE;
                prev_q  <= SYM_J;
              end
            end else begin
              cnt_q <= 3'd0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            prev_q  <= SYM_J;
          end
        endcase
      end
    end
  end

  assign bus.line_state = line_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_active  = rx_active_q;
  assign bus.rx_error   = rx_error_q;
  assign bus.bus_reset  = bus_reset_q;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Bench for usb_rx_phy: table of packets on an LS (16 clk/bit) and an FS (4 clk/bit)
// instance, plus hand-written bus-reset, reset_n and rx_en sequences.
module tb_usb_rx_phy;

  localparam int CPB_LS = 16;
  localparam int CPB_FS = 4;
  localparam int SJ = 0, SK = 1, SSE0 = 2;
  localparam int M_NORM = 0, M_STUFF = 1, M_SE0 = 2, M_BADSYNC = 3;
  localparam logic [4:0] SE0_BITS = 5'b10110;

  typedef struct {
    bit          fs;
    bit          jit;
    int          mode;
    int          n;
    logic [31:0] b;
    int          exp_valid;
    logic [31:0] exp_b;
    int          exp_err;
    int          exp_act;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  usb_rx_phy_if bus_ls ();
  usb_rx_phy_if bus_fs ();

  usb_rx_phy #(.CLK_PER_BIT(16), .LOW_SPEED(1'b1), .RESET_CYCLES(60)) u_ls (
    .clk(clk), .reset_n(reset_n), .bus(bus_ls)
  );
  usb_rx_phy #(.CLK_PER_BIT(4), .LOW_SPEED(1'b0), .RESET_CYCLES(60)) u_fs (
    .clk(clk), .reset_n(reset_n), .bus(bus_fs)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit fs_sel = 1'b0;
  int unsigned mon_valid = 0, mon_err = 0, mon_act = 0, mon_br = 0, mon_ovl = 0;
  logic [7:0] rxq[$];
  int syms[$];
  int lvl_s, ones_s;
  vec_t vecs[9];

  // Output monitor on the selected instance, sampled away from the active edge
  always @(negedge clk) begin
    logic v, a, e, b;
    logic [7:0] d;
    v = fs_sel ? bus_fs.rx_valid  : bus_ls.rx_valid;
    a = fs_sel ? bus_fs.rx_active : bus_ls.rx_active;
    e = fs_sel ? bus_fs.rx_error  : bus_ls.rx_error;
    b = fs_sel ? bus_fs.bus_reset : bus_ls.bus_reset;
    d = fs_sel ? bus_fs.rx_data   : bus_ls.rx_data;
    if (v) begin
      mon_valid++;
      rxq.push_back(d);
    end
    if (e) mon_err++;
    if (a) mon_act++;
    if (b) mon_br++;
    if (v && e) mon_ovl++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(bit fs, bit jit, int mode, int n, logic [31:0] b,
                              int ev, logic [31:0] eb, int ee, int ea);
    vec_t v;
    v.fs = fs; v.jit = jit; v.mode = mode; v.n = n; v.b = b;
    v.exp_valid = ev; v.exp_b = eb; v.exp_err = ee; v.exp_act = ea;
    return v;
  endfunction

  task automatic set_line(input bit fs, input int s);
    logic [1:0] code;
    if (s == SSE0)    code = 2'b00;
    else if (s == SJ) code = fs ? 2'b10 : 2'b01;
    else              code = fs ? 2'b01 : 2'b10;
    if (fs) bus_fs.d_i = code;
    else    bus_ls.d_i = code;
  endtask

  task automatic put_sync(input bit bad);
    for (int i = 0; i < 8; i++)
      syms.push_back(((i == 7 && !bad) || (i % 2 == 0)) ? SK : SJ);
    lvl_s  = SK;
    ones_s = 0;
  endtask

  // NRZI encoder with optional stuffing after six consecutive ones
  task automatic put_bit(input bit b, input bit stuff);
    if (!b) lvl_s = (lvl_s == SJ) ? SK : SJ;
    syms.push_back(lvl_s);
    ones_s = b ? ones_s + 1 : 0;
    if (stuff && ones_s == 6) begin
      lvl_s = (lvl_s == SJ) ? SK : SJ;
      syms.push_back(lvl_s);
      ones_s = 0;
    end
  endtask

  task automatic build(input vec_t v);
    syms.delete();
    put_sync(v.mode == M_BADSYNC);
    if (v.mode != M_BADSYNC) begin
      for (int k = 0; k < v.n; k++)
        for (int i = 0; i < 8; i++) put_bit(v.b[8*k+i], 1'b1);
      if (v.mode == M_STUFF) begin
        for (int i = 0; i < 7; i++) put_bit(1'b1, 1'b0);
      end else begin
        if (v.mode == M_SE0)
          for (int i = 0; i < 5; i++) put_bit(SE0_BITS[i], 1'b1);
        syms.push_back(SSE0);
        syms.push_back(SSE0);
        syms.push_back(SJ);
      end
    end
    repeat (12) syms.push_back(SJ);
  endtask

  // Plays syms; with jit each transition lands 2 clk early or late
  task automatic drive(input bit fs, input bit jit);
    int cpb;
    int off_cur;
    int off_nxt;
    cpb = fs ? CPB_FS : CPB_LS;
    off_cur = 0;
    for (int i = 0; i < syms.size(); i++) begin
      off_nxt = 0;
      if (jit && i + 1 < syms.size() && syms[i+1] != syms[i])
        off_nxt = ($urandom_range(0, 1) == 0) ? -2 : 2;
      set_line(fs, syms[i]);
      repeat (cpb + off_nxt - off_cur) @(negedge clk);
      off_cur = off_nxt;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int unsigned v0, e0, a0;
    int q0;
    logic [31:0] got;
    fs_sel = v.fs;
    v0 = mon_valid; e0 = mon_err; a0 = mon_act; q0 = rxq.size();
    build(v);
    drive(v.fs, v.jit);
    chk($sformatf("v%0d valid_cnt", id), mon_valid - v0, 32'(v.exp_valid));
    for (int k = 0; k < v.exp_valid; k++) begin
      got = (q0 + k < rxq.size()) ? 32'(rxq[q0+k]) : 32'hxxxx_xxxx;
      chk($sformatf("v%0d rx_data[%0d]", id, k), got, 32'(v.exp_b[8*k +: 8]));
    end
    chk($sformatf("v%0d err_cnt", id), mon_err - e0, 32'(v.exp_err));
    if (v.exp_act >= 0)
      chk($sformatf("v%0d active_cycles", id), mon_act - a0, 32'(v.exp_act));
    else
      chk($sformatf("v%0d active_seen", id), 32'((mon_act - a0) != 0), 32'd1);
    chk($sformatf("v%0d active_idle", id),
        32'(v.fs ? bus_fs.rx_active : bus_ls.rx_active), 32'd0);
  endtask

  initial begin
    int unsigned b0, e0, v0;

    // Active cycles = (data symbols incl. stuff bits + SE0,SE0,J) * clk per bit
    vecs[0] = mk(0, 0, M_NORM,    2, 32'h0000_3CA5, 2, 32'h0000_3CA5, 0, 304);
    vecs[1] = mk(0, 0, M_NORM,    3, 32'h00FF_FF00, 3, 32'h00FF_FF00, 0, 464);
    vecs[2] = mk(0, 0, M_STUFF,   1, 32'h0000_0000, 1, 32'h0000_0000, 1, 240);
    vecs[3] = mk(0, 0, M_NORM,    1, 32'h0000_00A5, 1, 32'h0000_00A5, 0, 176);
    vecs[4] = mk(0, 0, M_SE0,     0, 32'h0,         0, 32'h0,         1, 96);
    vecs[5] = mk(0, 0, M_BADSYNC, 0, 32'h0,         0, 32'h0,         0, 0);
    vecs[6] = mk(0, 1, M_NORM,    3, 32'h00FF_3CA5, 3, 32'h00FF_3CA5, 0, -1);
    vecs[7] = mk(0, 1, M_NORM,    2, 32'h0000_5A00, 2, 32'h0000_5A00, 0, -1);
    vecs[8] = mk(1, 0, M_NORM,    2, 32'h0000_3CA5, 2, 32'h0000_3CA5, 0, 76);

    reset_n = 1'b0;
    bus_ls.rx_en = 1'b1;
    bus_fs.rx_en = 1'b1;
    set_line(1'b0, SJ);
    set_line(1'b1, SJ);
    repeat (3) @(negedge clk);
    chk("reset line_state", 32'(bus_ls.line_state), 32'd0);
    chk("reset rx_data", 32'(bus_ls.rx_data), 32'd0);
    chk("reset flags", 32'({bus_ls.rx_valid, bus_ls.rx_active, bus_ls.rx_error, bus_ls.bus_reset}), 32'd0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle line_state", 32'(bus_ls.line_state), 32'h1);

    for (int t = 0; t < 9; t++) run_vec(vecs[t], t);

    // Bus reset threshold: 59 SE0 cycles short, 60 reach it, one J cycle clears
    fs_sel = 1'b0;
    b0 = mon_br;
    set_line(1'b0, SSE0);
    repeat (59) @(negedge clk);
    set_line(1'b0, SJ);
    repeat (10) @(negedge clk);
    chk("bus_reset 59", mon_br - b0, 32'd0);
    b0 = mon_br;
    set_line(1'b0, SSE0);
    repeat (60) @(negedge clk);
    set_line(1'b0, SJ);
    repeat (10) @(negedge clk);
    chk("bus_reset 60", mon_br - b0, 32'd1);
    set_line(1'b0, SSE0);
    repeat (70) @(negedge clk);
    chk("bus_reset held", 32'(bus_ls.bus_reset), 32'd1);
    set_line(1'b0, SJ);
    @(negedge clk);
    set_line(1'b0, SSE0);
    repeat (3) @(negedge clk);
    chk("bus_reset J clears", 32'(bus_ls.bus_reset), 32'd0);
    set_line(1'b0, SJ);
    repeat (20) @(negedge clk);

    // reset_n mid-byte
    syms.delete();
    put_sync(1'b0);
    for (int i = 0; i < 4; i++) put_bit(vecs[3].b[i], 1'b1);
    drive(1'b0, 1'b0);
    chk("pre-reset rx_active", 32'(bus_ls.rx_active), 32'd1);
    chk("pre-reset rx_data", 32'(bus_ls.rx_data), 32'h5A);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midbyte reset line_state", 32'(bus_ls.line_state), 32'd0);
    chk("midbyte reset rx_data", 32'(bus_ls.rx_data), 32'd0);
    chk("midbyte reset flags", 32'({bus_ls.rx_valid, bus_ls.rx_active, bus_ls.rx_error, bus_ls.bus_reset}), 32'd0);
    reset_n = 1'b1;
    set_line(1'b0, SJ);
    repeat (40) @(negedge clk);
    run_vec(vecs[0], 10);

    // rx_en dropped mid-packet
    syms.delete();
    put_sync(1'b0);
    for (int i = 0; i < 8; i++) put_bit(vecs[3].b[i], 1'b1);
    for (int i = 0; i < 3; i++) put_bit(SE0_BITS[i+1], 1'b1);
    drive(1'b0, 1'b0);
    chk("pre-rx_en rx_active", 32'(bus_ls.rx_active), 32'd1);
    e0 = mon_err;
    v0 = mon_valid;
    bus_ls.rx_en = 1'b0;
    @(negedge clk);
    chk("rx_en off rx_active", 32'(bus_ls.rx_active), 32'd0);
    chk("rx_en off pulses", 32'({bus_ls.rx_valid, bus_ls.rx_error}), 32'd0);
    set_line(1'b0, SSE0);
    repeat (2 * CPB_LS) @(negedge clk);
    set_line(1'b0, SJ);
    repeat (10 * CPB_LS) @(negedge clk);
    chk("rx_en off err_cnt", mon_err - e0, 32'd0);
    chk("rx_en off valid_cnt", mon_valid - v0, 32'd0);
    bus_ls.rx_en = 1'b1;
    repeat (20) @(negedge clk);
    run_vec(vecs[0], 11);

    chk("valid with error", mon_ovl, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
